// File: rtl/mem_read_arbiter_if.sv
// Request, response and memory-port signals shared by the fetch/load requesters and the arbiter.
// Bit numbering is MSB=0, matching the core.
interface mem_read_arbiter_if;
  logic        f_valid;
  logic [0:60] f_addr;
  logic        f_ready;
  logic        f_flush;
  logic        f_rvalid;
  logic [0:63] f_rdata;

  logic        l_valid;
  logic [0:60] l_addr;
  logic        l_ready;
  logic        l_rvalid;
  logic [0:63] l_rdata;

  logic        mem_en;
  logic [0:60] mem_addr;
  logic [0:63] mem_rdata;

  logic [0:31] f_grants;
  logic [0:31] l_grants;

  // Arbiter side.
  modport slave (
    input  f_valid, f_addr, f_flush, l_valid, l_addr, mem_rdata,
    output f_ready, f_rvalid, f_rdata, l_ready, l_rvalid, l_rdata,
           mem_en, mem_addr, f_grants, l_grants
  );

  // Requester / memory side.
  modport master (
    output f_valid, f_addr, f_flush, l_valid, l_addr, mem_rdata,
    input  f_ready, f_rvalid, f_rdata, l_ready, l_rvalid, l_rdata,
           mem_en, mem_addr, f_grants, l_grants
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between fetch (F) and load (L): load priority with a fetch
// anti-starvation counter, and a tag pipeline that routes each response back to its issuer.
module mem_read_arbiter #(
  parameter int LAT      = 1,  // memory read latency, 1..4
  parameter int MAX_WAIT = 3   // denied fetch cycles before fetch wins, 1..15
) (
  input  logic              clk,
  input  logic              rst,
  mem_read_arbiter_if.slave bus
);

  typedef struct packed {
    logic valid;
    logic id;     // 0 = fetch, 1 = load
  } tag_t;

  logic [3:0]  starve;
  logic        starved;
  logic        fReady;
  logic        lReady;
  logic        memEn;
  logic        fRvalid;
  logic        lRvalid;
  tag_t        tagQ [LAT];
  tag_t        lastTag;
  logic [0:31] fGrants;
  logic [0:31] lGrants;

  // A flush kills fetch-tagged entries only; load entries pass untouched.
  function automatic tag_t flushTag(input tag_t t, input logic flush);
    return '{valid: t.valid & ~(flush & ~t.id), id: t.id};
  endfunction

  // NOTE: grant is pure continuous logic, so every output has a single unconditional driver and no latch can form.
  assign starved      = (starve == 4'(MAX_WAIT));
  assign fReady       = bus.f_valid & (~bus.l_valid | starved);
  assign lReady       = bus.l_valid & ~fReady;
  assign memEn        = fReady | lReady;

  assign bus.f_ready  = fReady;
  assign bus.l_ready  = lReady;
  assign bus.mem_en   = memEn;
  assign bus.mem_addr = fReady ? bus.f_addr : (lReady ? bus.l_addr : '0);

  assign lastTag      = tagQ[LAT-1];
  assign fRvalid      = lastTag.valid & ~lastTag.id;
  assign lRvalid      = lastTag.valid &  lastTag.id;

  assign bus.f_rvalid = fRvalid;
  assign bus.l_rvalid = lRvalid;
  assign bus.f_rdata  = fRvalid ? bus.mem_rdata : '0;
  assign bus.l_rdata  = lRvalid ? bus.mem_rdata : '0;
  assign bus.f_grants = fGrants;
  assign bus.l_grants = lGrants;

  // NOTE: state updates use non-blocking assignments so every stage shifts from its pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve  <= '0;
      fGrants <= '0;
      lGrants <= '0;
      // NOTE: only valid bits matter, but ids are cleared too so no X ever reaches the response outputs.
      for (int i = 0; i < LAT; i++) tagQ[i] <= '0;
    end else begin
      if (bus.f_valid & ~fReady) starve <= starved ? starve : starve + 4'd1;
      else                       starve <= '0;

      fGrants <= fGrants + 32'(fReady);
      lGrants <= lGrants + 32'(lReady);

      tagQ[0] <= flushTag('{valid: memEn, id: lReady}, bus.f_flush);
      for (int i = 1; i < LAT; i++) tagQ[i] <= flushTag(tagQ[i-1], bus.f_flush);
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed table and sequences plus random traffic
// compared against a queue-based model of outstanding reads.
module tb_mem_read_arbiter;
  localparam int LAT      = 4;
  localparam int MAX_WAIT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_read_arbiter_if bus ();

  mem_read_arbiter #(.LAT(LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: data for the read issued LAT cycles ago is addr + 0x100; junk otherwise.
  logic [63:0] memPipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) memPipe[i] <= memPipe[i-1];
    memPipe[0] <= bus.mem_en ? ({3'b0, bus.mem_addr} + 64'h100) : 64'hDEAD_BEEF_0BAD_F00D;
  end
  assign bus.mem_rdata = memPipe[LAT-1];

  // Response sightings, used by the directed sequences.
  int fRvSeen = 0;
  int lRvSeen = 0;
  always @(negedge clk) begin
    if (bus.f_rvalid === 1'b1) fRvSeen <= fRvSeen + 1;
    if (bus.l_rvalid === 1'b1) lRvSeen <= lRvSeen + 1;
  end

  // Reference model: outstanding reads with the cycle their response is due.
  typedef struct {
    int          due;
    bit          isLoad;
    logic [63:0] data;
    bit          live;
  } resp_t;

  resp_t       pend[$];
  int          cyc;
  int          starveM;
  logic [31:0] fGrM, lGrM;
  bit          mF, mL, mRvF, mRvL;
  logic [63:0] mAddr, mData;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
  endtask

  task automatic drive(input bit fv, input logic [60:0] fa, input bit lv, input logic [60:0] la,
                       input bit fl);
    bus.f_valid = fv;
    bus.f_addr  = fa;
    bus.l_valid = lv;
    bus.l_addr  = la;
    bus.f_flush = fl;
  endtask

  task automatic evalAndCheck();
    mF    = bus.f_valid && (!bus.l_valid || starveM == MAX_WAIT);
    mL    = bus.l_valid && !mF;
    mAddr = mF ? 64'(bus.f_addr) : (mL ? 64'(bus.l_addr) : 64'd0);
    mRvF  = 1'b0;
    mRvL  = 1'b0;
    mData = '0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc && pend[i].live) begin
        mRvL  = pend[i].isLoad;
        mRvF  = !pend[i].isLoad;
        mData = pend[i].data;
      end
    end
    @(negedge clk);
    check("f_ready",  64'(bus.f_ready),  64'(mF));
    check("l_ready",  64'(bus.l_ready),  64'(mL));
    check("mem_en",   64'(bus.mem_en),   64'(mF || mL));
    check("mem_addr", 64'(bus.mem_addr), mAddr);
    check("f_rvalid", 64'(bus.f_rvalid), 64'(mRvF));
    check("l_rvalid", 64'(bus.l_rvalid), 64'(mRvL));
    check("f_rdata",  64'(bus.f_rdata),  mRvF ? mData : 64'd0);
    check("l_rdata",  64'(bus.l_rdata),  mRvL ? mData : 64'd0);
    check("f_grants", 64'(bus.f_grants), 64'(fGrM));
    check("l_grants", 64'(bus.l_grants), 64'(lGrM));
  endtask

  task automatic advance();
    @(posedge clk);
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    if (rst) begin
      pend.delete();
      starveM = 0;
      fGrM    = '0;
      lGrM    = '0;
    end else begin
      if (bus.f_flush) foreach (pend[i]) if (!pend[i].isLoad) pend[i].live = 1'b0;
      if (mF || mL)
        pend.push_back('{due: cyc + LAT, isLoad: mL, data: mAddr + 64'h100,
                         live: !(mF && bus.f_flush)});
      if (mF) fGrM = fGrM + 32'd1;
      if (mL) lGrM = lGrM + 32'd1;
      if (bus.f_valid && !mF) starveM = (starveM < MAX_WAIT) ? starveM + 1 : starveM;
      else                    starveM = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    evalAndCheck();
    advance();
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (n) step();
  endtask

  task automatic doReset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit fv, lv, expF, expL;
  } vec_t;

  vec_t vecs [12];
  int   f0, l0;

  initial begin
    // Both valid: L,L,L,F twice; then single-requester and idle rows; then starve restarts at 0.
    vecs[0]  = '{1, 1, 0, 1};
    vecs[1]  = '{1, 1, 0, 1};
    vecs[2]  = '{1, 1, 0, 1};
    vecs[3]  = '{1, 1, 1, 0};
    vecs[4]  = '{1, 1, 0, 1};
    vecs[5]  = '{1, 1, 0, 1};
    vecs[6]  = '{1, 1, 0, 1};
    vecs[7]  = '{1, 1, 1, 0};
    vecs[8]  = '{1, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 1};
    vecs[10] = '{0, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 1};

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    cyc = 0; starveM = 0; fGrM = '0; lGrM = '0;
    repeat (LAT + 2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state with both valids low.
    step();

    // Fetch only, consecutive addresses 0 and 1.
    f0 = fRvSeen;
    drive(1'b1, 61'd0, 1'b0, '0, 1'b0); step();
    drive(1'b1, 61'd1, 1'b0, '0, 1'b0); step();
    idle(LAT + 1);
    check("t1_f_grants", 64'(bus.f_grants), 64'd2);
    check("t1_f_responses", 64'(fRvSeen - f0), 64'd2);

    // Load priority and fetch anti-starvation.
    doReset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fv, 61'h1000 + 61'(i), vecs[i].lv, 61'h2000 + 61'(i), 1'b0);
      evalAndCheck();
      check($sformatf("vec%0d_f_ready", i), 64'(bus.f_ready), 64'(vecs[i].expF));
      check($sformatf("vec%0d_l_ready", i), 64'(bus.l_ready), 64'(vecs[i].expL));
      advance();
      if (i == 7) begin
        check("t2_l_grants", 64'(bus.l_grants), 64'd6);
        check("t2_f_grants", 64'(bus.f_grants), 64'd2);
      end
    end
    idle(LAT + 1);

    // Routing: F, L, F back to back return in order to the right requester.
    doReset();
    f0 = fRvSeen; l0 = lRvSeen;
    drive(1'b1, 61'h10, 1'b0, '0, 1'b0);    step();
    drive(1'b0, '0, 1'b1, 61'h20, 1'b0);    step();
    drive(1'b1, 61'h30, 1'b0, '0, 1'b0);    step();
    idle(LAT + 1);
    check("t3_f_responses", 64'(fRvSeen - f0), 64'd2);
    check("t3_l_responses", 64'(lRvSeen - l0), 64'd1);

    // Flush: one fetch in flight, one loaded at the flush edge; the load survives.
    doReset();
    f0 = fRvSeen; l0 = lRvSeen;
    drive(1'b1, 61'h40, 1'b0, '0, 1'b0);    step();
    drive(1'b0, '0, 1'b1, 61'h50, 1'b1);    step();
    drive(1'b1, 61'h60, 1'b0, '0, 1'b1);    step();
    idle(LAT + 1);
    check("t4_f_responses", 64'(fRvSeen - f0), 64'd0);
    check("t4_l_responses", 64'(lRvSeen - l0), 64'd1);
    check("t4_f_grants", 64'(bus.f_grants), 64'd2);
    check("t4_l_grants", 64'(bus.l_grants), 64'd1);

    // Reset mid-flight drops every outstanding read.
    doReset();
    f0 = fRvSeen; l0 = lRvSeen;
    drive(1'b1, 61'h70, 1'b0, '0, 1'b0);    step();
    drive(1'b0, '0, 1'b1, 61'h80, 1'b0);    step();
    drive(1'b1, 61'h90, 1'b0, '0, 1'b0);    step();
    doReset();
    idle(LAT + 1);
    check("t5_f_responses", 64'(fRvSeen - f0), 64'd0);
    check("t5_l_responses", 64'(lRvSeen - l0), 64'd0);
    check("t5_f_grants", 64'(bus.f_grants), 64'd0);
    check("t5_l_grants", 64'(bus.l_grants), 64'd0);
    f0 = fRvSeen;
    drive(1'b1, 61'hA0, 1'b0, '0, 1'b0);
    evalAndCheck();
    check("t5_next_f_ready", 64'(bus.f_ready), 64'd1);
    advance();
    idle(LAT + 1);
    check("t5_next_f_response", 64'(fRvSeen - f0), 64'd1);

    // Load counter wraps from all-ones to zero; fetch counter holds.
    doReset();
    drive(1'b1, 61'hB0, 1'b0, '0, 1'b0);    step();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    force dut.lGrants = 32'hFFFF_FFFF;
    lGrM = 32'hFFFF_FFFF;
    step();
    release dut.lGrants;
    step();
    drive(1'b0, '0, 1'b1, 61'hC0, 1'b0);    step();
    check("t6_l_grants_wrap", 64'(bus.l_grants), 64'd0);
    check("t6_f_grants_held", 64'(bus.f_grants), 64'd1);
    idle(LAT + 1);

    // Random traffic against the model, with occasional flushes and resets.
    doReset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 6, 61'({$urandom(), $urandom()}),
            $urandom_range(0, 9) < 7, 61'({$urandom(), $urandom()}),
            $urandom_range(0, 7) == 0);
      step();
    end
    rst = 1'b0;
    idle(LAT + 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
